mic_delay_buf: RTL and testbench

- Parametrised multi-channel circular sample buffer for the microphone array front end.
- Stores the last DEPTH frames; each frame holds CH samples of W bits.
- Serves random-access reads as "channel c, d frames ago" to the delay-and-sum beamformer.
- Generalises the fixed 512x16 single-channel block RAM into a CH-wide ring with write-pointer management, fill tracking and delay-relative addressing.

---
 rtl/mic_pkg.sv | 15 +
 rtl/sdp_ram_bank.sv | 28 ++
 rtl/mic_delay_buf.sv | 131 +++++++++++++
 tb/tb_mic_delay_buf.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared constants, sample type and frame-slicing helper for the microphone delay buffer.
package mic_pkg;

  localparam int unsigned ChDefault    = 8;
  localparam int unsigned WDefault     = 16;
  localparam int unsigned DepthDefault = 512;

  typedef logic signed [WDefault-1:0] sample_t;

  // LSB position of channel ch inside a packed frame of w-bit samples.
  function automatic int unsigned chan_lsb(int unsigned ch, int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// Generic DEPTH x W simple-dual-port synchronous RAM, read-before-write.
// Single substitution point for a vendor block-RAM primitive.
module sdp_ram_bank #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned W     = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Non-blocking read of r_mem returns the pre-write word on address collisions.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mic_delay_buf.sv
// Multi-channel circular sample buffer with delay-relative reads.
// Define MIC_DELAY_BUF_RD_PIPE_EN to add an output register (2-cycle read latency).
module mic_delay_buf
  import mic_pkg::*;
#(
  parameter int unsigned CH    = ChDefault,
  parameter int unsigned W     = WDefault,
  parameter int unsigned DEPTH = DepthDefault,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [CH*W-1:0] in_data,
  input  logic            rd_req,
  input  logic [CW-1:0]   rd_ch,
  input  logic [AW-1:0]   rd_delay,
  output logic            rd_valid,
  output logic [W-1:0]    rd_data,
  output logic            rd_err,
  output logic [AW:0]     fill,
  output logic            full
);

  localparam logic [AW:0] FillMax = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_fill;
  logic          w_we;
  logic [AW-1:0] w_rd_addr;
  logic          w_err;
  logic          r_v1;
  logic          r_err1;
  logic [CW-1:0] r_ch1;
  logic [W-1:0]  w_bank_q [CH];
  logic [W-1:0]  w_mux;
  logic [W-1:0]  w_s1_data;
  logic          w_out_v;
  logic          w_out_err;
  logic [W-1:0]  w_out_data;

  assign full = (r_fill == FillMax);
  assign fill = r_fill;

  // clr wins over a same-cycle write, so the frame never reaches memory.
  assign w_we      = in_valid && !clr && !reset;
  assign w_rd_addr = r_wr_ptr - AW'(1) - rd_delay;
  assign w_err     = ({1'b0, rd_delay} >= r_fill) || (32'(rd_ch) >= CH);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (in_valid) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (!full) r_fill <= r_fill + (AW+1)'(1);
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_bank
    sdp_ram_bank #(
      .DEPTH (DEPTH),
      .W     (W),
      .AW    (AW)
    ) u_bank (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_data[chan_lsb(k, W) +: W]),
      .i_re    (rd_req),
      .i_raddr (w_rd_addr),
      .o_rdata (w_bank_q[k])
    );
  end

  // Request-side tags travel alongside the bank read; clr leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_err1 <= 1'b0;
      r_ch1  <= '0;
    end else begin
      r_v1   <= rd_req;
      r_err1 <= rd_req && w_err;
      r_ch1  <= rd_ch;
    end
  end

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < CH; k++) begin
      if (r_ch1 == CW'(k)) w_mux = w_bank_q[k];
    end
  end

  assign w_s1_data = (r_v1 && !r_err1) ? w_mux : '0;

`ifdef MIC_DELAY_BUF_RD_PIPE_EN
  logic         r_v2;
  logic         r_err2;
  logic [W-1:0] r_data2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2    <= 1'b0;
      r_err2  <= 1'b0;
      r_data2 <= '0;
    end else begin
      r_v2    <= r_v1;
      r_err2  <= r_v1 && r_err1;
      r_data2 <= w_s1_data;
    end
  end

  assign w_out_v    = r_v2;
  assign w_out_err  = r_err2;
  assign w_out_data = r_data2;
`else
  assign w_out_v    = r_v1;
  assign w_out_err  = r_v1 && r_err1;
  assign w_out_data = w_s1_data;
`endif

  // Reset suppresses a result already sitting on the outputs.
  assign rd_valid = w_out_v && !reset;
  assign rd_err   = w_out_err && !reset;
  assign rd_data  = (w_out_v && !reset) ? w_out_data : '0;

endmodule

// File: tb/tb_mic_delay_buf.sv
// Scoreboard bench for mic_delay_buf; expected reads come from a frame-history model.
module tb_mic_delay_buf;

  localparam int CH    = 8;
  localparam int W     = 16;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int CW    = 3;
`ifdef MIC_DELAY_BUF_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            clr;
  logic            in_valid;
  logic [CH*W-1:0] in_data;
  logic            rd_req;
  logic [CW-1:0]   rd_ch;
  logic [AW-1:0]   rd_delay;
  logic            rd_valid;
  logic [W-1:0]    rd_data;
  logic            rd_err;
  logic [AW:0]     fill;
  logic            full;

  mic_delay_buf #(
    .CH    (CH),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .rd_req   (rd_req),
    .rd_ch    (rd_ch),
    .rd_delay (rd_delay),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .fill     (fill),
    .full     (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           due;
  } exp_t;

  exp_t            sb[$];
  logic [CH*W-1:0] hist[$];
  int              m_fill = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  logic            mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CH*W-1:0] make_frame(input int base, input int f, input bit per_ch);
    logic [CH*W-1:0] fr;
    for (int k = 0; k < CH; k++) fr[k*W +: W] = W'(per_ch ? base + f * 16 + k : f);
    return fr;
  endfunction

  // One clock of stimulus; the model sees request-cycle state before this cycle's write.
  task automatic drive(input logic v, input logic [CH*W-1:0] d, input logic c,
                       input logic rq, input int ch, input int dly);
    exp_t            e;
    logic [CH*W-1:0] fr;
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    clr      = c;
    rd_req   = rq;
    rd_ch    = CW'(ch);
    rd_delay = AW'(dly);
    if (rq) begin
      e.due = cyc + LAT;
      if (dly >= m_fill || ch >= CH) begin
        e.err  = 1'b1;
        e.data = '0;
      end else begin
        e.err  = 1'b0;
        fr     = hist[hist.size() - 1 - dly];
        e.data = fr[ch*W +: W];
      end
      sb.push_back(e);
    end
    if (c) m_fill = 0;
    else if (v) begin
      hist.push_back(d);
      if (m_fill < DEPTH) m_fill++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_req   = 1'b0;
    rd_ch    = '0;
    rd_delay = '0;
    sb.delete();
    hist.delete();
    m_fill = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rd_valid) begin
        if (sb.size() == 0) check("spurious_valid", 32'(rd_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_err", 32'(rd_err), 32'(e.err));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("idle_outputs", 32'({rd_data, rd_err}), 32'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_valid", 32'(rd_valid), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);

    // Three frames, then delay-relative reads on ch2 and ch5.
    for (int f = 0; f < 3; f++) drive(1'b1, make_frame(16'h1000, f, 1'b1), 1'b0, 1'b0, 0, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 2, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 2, 1);
    drive(1'b0, '0, 1'b0, 1'b1, 2, 2);
    drive(1'b0, '0, 1'b0, 1'b1, 2, 3);
    drive(1'b0, '0, 1'b0, 1'b1, 5, 0);
    idle(1);
    check("fill_3", 32'(fill), 32'd3);
    check("full_3", 32'(full), 32'd0);
    idle(3);

    // Wrap past DEPTH: fill saturates and the oldest frames are overwritten.
    do_reset();
    for (int f = 0; f < 600; f++) drive(1'b1, make_frame(0, f, 1'b0), 1'b0, 1'b0, 0, 0);
    idle(1);
    check("fill_sat", 32'(fill), 32'd512);
    check("full_sat", 32'(full), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 0, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 3, 511);
    drive(1'b0, '0, 1'b0, 1'b1, 7, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1, 256);
    // Same-cycle write and read sees the previous frame; the next cycle sees the new one.
    drive(1'b1, make_frame(0, 16'hABCD, 1'b0), 1'b0, 1'b1, 4, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 4, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 6, 511);
    idle(1);
    check("fill_still_sat", 32'(fill), 32'd512);
    idle(3);

    // clr with a concurrent write and an in-flight read.
    do_reset();
    for (int f = 0; f < 10; f++) drive(1'b1, make_frame(16'h2000, f, 1'b1), 1'b0, 1'b0, 0, 0);
    drive(1'b1, make_frame(16'h3000, 0, 1'b1), 1'b1, 1'b1, 1, 0);
    idle(1);
    check("clr_fill", 32'(fill), 32'd0);
    check("clr_full", 32'(full), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 0, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 3, 5);
    drive(1'b1, make_frame(16'h4000, 1, 1'b1), 1'b0, 1'b0, 0, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 3, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 3, 1);
    idle(1);
    check("post_clr_fill", 32'(fill), 32'd1);
    idle(3);

    // Reset one cycle after a request drops it.
    @(posedge clk);
    #1;
    rd_req   = 1'b1;
    rd_ch    = CW'(2);
    rd_delay = '0;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_drop_valid", 32'(rd_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fill = 0;
    hist.delete();
    idle(2);
    check("rst_drop_fill", 32'(fill), 32'd0);

    idle(LAT + 3);
    check("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
